// File: rtl/css_color_resolver.sv
// css_color_resolver: resolves a CSS value ident to a 32-bit ARGB color.
// Special document keywords resolve in one cycle; everything else is looked up in a
// runtime-programmable color table that is scanned LANES entries per cycle.
// Optional feature macro: CSS_COLOR_STATS_EN (table-scan hit/miss counters).
module css_color_resolver #(
  parameter int unsigned IDENT_W = 10,
  parameter int unsigned COLOR_W = 32,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LANES   = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  // Request
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_is_ident,
  input  logic [IDENT_W-1:0]         req_ident,
  input  logic                       req_is_link,
  input  logic                       req_is_visited,
  input  logic [COLOR_W-1:0]         req_inherited_color,
  // Special keyword ids
  input  logic [IDENT_W-1:0]         cfg_text_id,
  input  logic [IDENT_W-1:0]         cfg_link_id,
  input  logic [IDENT_W-1:0]         cfg_alink_id,
  input  logic [IDENT_W-1:0]         cfg_focus_id,
  input  logic [IDENT_W-1:0]         cfg_current_id,
  // Document colors
  input  logic [COLOR_W-1:0]         doc_text_color,
  input  logic [COLOR_W-1:0]         doc_link_color,
  input  logic [COLOR_W-1:0]         doc_vlink_color,
  input  logic [COLOR_W-1:0]         doc_alink_color,
  input  logic [COLOR_W-1:0]         focus_ring_color,
  // Color table write port
  input  logic                       tbl_wr_en,
  output logic                       tbl_wr_ready,
  input  logic [$clog2(DEPTH)-1:0]   tbl_wr_idx,
  input  logic                       tbl_wr_valid,
  input  logic [IDENT_W-1:0]         tbl_wr_ident,
  input  logic [COLOR_W-1:0]         tbl_wr_color,
  // Response
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [COLOR_W-1:0]         rsp_color,
  output logic                       rsp_hit,
  // Statistics
  input  logic                       stat_clr,
  output logic [CNT_W-1:0]           stat_hit_cnt,
  output logic [CNT_W-1:0]           stat_miss_cnt
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  // Base of the final chunk; reaching it without a match ends the scan as a miss.
  localparam logic [IdxW-1:0] LastBase = IdxW'(DEPTH - LANES);
  localparam logic [IdxW-1:0] LaneStep = IdxW'(LANES);

  typedef enum logic [1:0] {StIdle, StScan, StResp} state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      base_q, base_d;
  logic [IDENT_W-1:0]   ident_q, ident_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic                 hit_q, hit_d;
  // Marks that the pending response came from a table scan (only those are counted).
  logic                 scan_req_q, scan_req_d;

  logic [DEPTH-1:0]     tbl_valid_q, tbl_valid_d;
  logic [IDENT_W-1:0]   tbl_ident_q [DEPTH];
  logic [IDENT_W-1:0]   tbl_ident_d [DEPTH];
  logic [COLOR_W-1:0]   tbl_color_q [DEPTH];
  logic [COLOR_W-1:0]   tbl_color_d [DEPTH];

  logic                 idle;
  logic                 tbl_wr_fire;
  logic                 scan_match;
  logic [COLOR_W-1:0]   scan_color;
  logic                 rsp_fire;

  assign idle         = (state_q == StIdle);
  assign req_ready    = idle;
  assign tbl_wr_ready = idle;
  assign tbl_wr_fire  = tbl_wr_en & idle;
  assign rsp_valid    = (state_q == StResp);
  assign rsp_color    = color_q;
  assign rsp_hit      = hit_q;
  assign rsp_fire     = rsp_valid & rsp_ready;

  // Table next state: a single-entry write while idle.
  always_comb begin
    tbl_valid_d = tbl_valid_q;
    tbl_ident_d = tbl_ident_q;
    tbl_color_d = tbl_color_q;
    if (tbl_wr_fire) begin
      tbl_valid_d[tbl_wr_idx] = tbl_wr_valid;
      tbl_ident_d[tbl_wr_idx] = tbl_wr_ident;
      tbl_color_d[tbl_wr_idx] = tbl_wr_color;
    end
  end

  // Table valid bits are reset so a reset empties the table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_valid_q <= '0;
    end else begin
      tbl_valid_q <= tbl_valid_d;
    end
  end

  // Table payload needs no reset; it is qualified by the valid bits.
  always_ff @(posedge clk) begin
    tbl_ident_q <= tbl_ident_d;
    tbl_color_q <= tbl_color_d;
  end

  // Compare the current chunk; the lowest matching lane wins so duplicates resolve low.
  always_comb begin
    scan_match = 1'b0;
    scan_color = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (!scan_match && tbl_valid_q[base_q + IdxW'(i)] &&
          (tbl_ident_q[base_q + IdxW'(i)] == ident_q)) begin
        scan_match = 1'b1;
        scan_color = tbl_color_q[base_q + IdxW'(i)];
      end
    end
  end

  // FSM next state: keyword classification, chunked scan, response hold.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    ident_d    = ident_q;
    color_d    = color_q;
    hit_d      = hit_q;
    scan_req_d = scan_req_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d    = StResp;
          hit_d      = 1'b1;
          scan_req_d = 1'b0;
          if (!req_is_ident || (req_ident == '0)) begin
            color_d = '0;
            hit_d   = 1'b0;
          end else if (req_ident == cfg_text_id) begin
            color_d = doc_text_color;
          end else if (req_ident == cfg_link_id) begin
            color_d = (req_is_link && req_is_visited) ? doc_vlink_color : doc_link_color;
          end else if (req_ident == cfg_alink_id) begin
            color_d = doc_alink_color;
          end else if (req_ident == cfg_focus_id) begin
            color_d = focus_ring_color;
          end else if (req_ident == cfg_current_id) begin
            color_d = req_inherited_color;
          end else begin
            state_d    = StScan;
            ident_d    = req_ident;
            base_d     = '0;
            hit_d      = 1'b0;
            scan_req_d = 1'b1;
          end
        end
      end
      StScan: begin
        if (scan_match) begin
          color_d = scan_color;
          hit_d   = 1'b1;
          state_d = StResp;
        end else if (base_q == LastBase) begin
          color_d = '0;
          hit_d   = 1'b0;
          state_d = StResp;
        end else begin
          base_d = base_q + LaneStep;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and response registers; reset aborts any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      base_q     <= '0;
      ident_q    <= '0;
      color_q    <= '0;
      hit_q      <= 1'b0;
      scan_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      ident_q    <= ident_d;
      color_q    <= color_d;
      hit_q      <= hit_d;
      scan_req_q <= scan_req_d;
    end
  end

`ifdef CSS_COLOR_STATS_EN
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  // Saturating scan hit/miss counters; clear beats a same-cycle increment.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (stat_clr) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (rsp_fire && scan_req_q) begin
      if (hit_q) begin
        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign stat_hit_cnt  = hit_cnt_q;
  assign stat_miss_cnt = miss_cnt_q;
`else
  // Statistics disabled: outputs tied off, inputs kept for a stable port list.
  logic unused_stats;
  assign unused_stats  = stat_clr ^ scan_req_q ^ rsp_fire;
  assign stat_hit_cnt  = '0;
  assign stat_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_css_color_resolver.sv
// Directed self-checking bench for css_color_resolver (DEPTH 64, LANES 4).
module tb_css_color_resolver;

  localparam int unsigned IDENT_W = 10;
  localparam int unsigned COLOR_W = 32;
  localparam int unsigned DEPTH   = 64;
  localparam int unsigned LANES   = 4;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned IdxW    = $clog2(DEPTH);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic               req_is_ident = 1'b0;
  logic [IDENT_W-1:0] req_ident = '0;
  logic               req_is_link = 1'b0;
  logic               req_is_visited = 1'b0;
  logic [COLOR_W-1:0] req_inherited_color = 32'hFF0A0B0C;
  logic [IDENT_W-1:0] cfg_text_id = 10'd701;
  logic [IDENT_W-1:0] cfg_link_id = 10'd700;
  logic [IDENT_W-1:0] cfg_alink_id = 10'd702;
  logic [IDENT_W-1:0] cfg_focus_id = 10'd703;
  logic [IDENT_W-1:0] cfg_current_id = 10'd704;
  logic [COLOR_W-1:0] doc_text_color = 32'hFF111111;
  logic [COLOR_W-1:0] doc_link_color = 32'hFF0000EE;
  logic [COLOR_W-1:0] doc_vlink_color = 32'hFF551A8B;
  logic [COLOR_W-1:0] doc_alink_color = 32'hFFEE0000;
  logic [COLOR_W-1:0] focus_ring_color = 32'hFF3B99FC;
  logic               tbl_wr_en = 1'b0;
  logic               tbl_wr_ready;
  logic [IdxW-1:0]    tbl_wr_idx = '0;
  logic               tbl_wr_valid = 1'b0;
  logic [IDENT_W-1:0] tbl_wr_ident = '0;
  logic [COLOR_W-1:0] tbl_wr_color = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [COLOR_W-1:0] rsp_color;
  logic               rsp_hit;
  logic               stat_clr = 1'b0;
  logic [CNT_W-1:0]   stat_hit_cnt;
  logic [CNT_W-1:0]   stat_miss_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int exp_hit = 0;
  int exp_miss = 0;
`ifdef CSS_COLOR_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  css_color_resolver #(
    .IDENT_W(IDENT_W), .COLOR_W(COLOR_W), .DEPTH(DEPTH), .LANES(LANES), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_ident(req_is_ident),
    .req_ident(req_ident), .req_is_link(req_is_link), .req_is_visited(req_is_visited),
    .req_inherited_color(req_inherited_color),
    .cfg_text_id(cfg_text_id), .cfg_link_id(cfg_link_id), .cfg_alink_id(cfg_alink_id),
    .cfg_focus_id(cfg_focus_id), .cfg_current_id(cfg_current_id),
    .doc_text_color(doc_text_color), .doc_link_color(doc_link_color),
    .doc_vlink_color(doc_vlink_color), .doc_alink_color(doc_alink_color),
    .focus_ring_color(focus_ring_color),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_ready(tbl_wr_ready), .tbl_wr_idx(tbl_wr_idx),
    .tbl_wr_valid(tbl_wr_valid), .tbl_wr_ident(tbl_wr_ident), .tbl_wr_color(tbl_wr_color),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_color(rsp_color), .rsp_hit(rsp_hit),
    .stat_clr(stat_clr), .stat_hit_cnt(stat_hit_cnt), .stat_miss_cnt(stat_miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_stats(input string tag);
    check_eq({tag, "_hitcnt"}, 64'(stat_hit_cnt), StatsEn ? 64'(exp_hit) : 64'd0);
    check_eq({tag, "_misscnt"}, 64'(stat_miss_cnt), StatsEn ? 64'(exp_miss) : 64'd0);
  endtask

  task automatic write_entry(input int idx, input logic v, input int ident, input logic [31:0] c);
    @(negedge clk);
    tbl_wr_en    = 1'b1;
    tbl_wr_idx   = IdxW'(idx);
    tbl_wr_valid = v;
    tbl_wr_ident = IDENT_W'(ident);
    tbl_wr_color = c;
    @(posedge clk);
    #1 tbl_wr_en = 1'b0;
  endtask

  // Counts cycles from the accept edge until rsp_valid, sampling on negedges.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    if (!rsp_valid) check_eq("rsp_timeout", 64'd0, 64'd1);
  endtask

  // Issues one request (plus any write already staged on tbl_wr_*) and consumes the response.
  task automatic do_req(input logic is_id, input int ident, input logic lnk, input logic vis,
                        output int lat, output logic [31:0] color, output logic hit);
    @(negedge clk);
    req_is_ident   = is_id;
    req_ident      = IDENT_W'(ident);
    req_is_link    = lnk;
    req_is_visited = vis;
    req_valid      = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    tbl_wr_en = 1'b0;
    wait_rsp(lat);
    color = rsp_color;
    hit   = rsp_hit;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [31:0] color;
    logic hit;

    // Reset state
    #12;
    check_eq("rst_req_ready", 64'(req_ready), 64'd1);
    check_eq("rst_wr_ready", 64'(tbl_wr_ready), 64'd1);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_rsp_color", 64'(rsp_color), 64'd0);
    check_eq("rst_rsp_hit", 64'(rsp_hit), 64'd0);
    check_stats("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Miss on empty table: full 16-chunk scan
    do_req(1'b1, 999, 1'b0, 1'b0, lat, color, hit);
    exp_miss++;
    check_eq("miss_lat", 64'(lat), 64'd17);
    check_eq("miss_color", 64'(color), 64'd0);
    check_eq("miss_hit", 64'(hit), 64'd0);
    check_stats("miss");

    // Table hit in chunk 1
    write_entry(5, 1'b1, 3, 32'hFF00FFFF);
    do_req(1'b1, 3, 1'b0, 1'b0, lat, color, hit);
    exp_hit++;
    check_eq("hit_lat", 64'(lat), 64'd3);
    check_eq("hit_color", 64'(color), 64'hFF00FFFF);
    check_eq("hit_hit", 64'(hit), 64'd1);
    check_stats("hit");

    // Link keyword, visited and unvisited
    do_req(1'b1, 700, 1'b1, 1'b1, lat, color, hit);
    check_eq("vlink_lat", 64'(lat), 64'd1);
    check_eq("vlink_color", 64'(color), 64'hFF551A8B);
    check_eq("vlink_hit", 64'(hit), 64'd1);
    do_req(1'b1, 700, 1'b1, 1'b0, lat, color, hit);
    check_eq("link_color", 64'(color), 64'hFF0000EE);
    do_req(1'b1, 701, 1'b0, 1'b0, lat, color, hit);
    check_eq("text_color", 64'(color), 64'hFF111111);
    do_req(1'b1, 702, 1'b0, 1'b0, lat, color, hit);
    check_eq("alink_color", 64'(color), 64'hFFEE0000);
    do_req(1'b1, 703, 1'b0, 1'b0, lat, color, hit);
    check_eq("focus_color", 64'(color), 64'hFF3B99FC);
    do_req(1'b1, 704, 1'b0, 1'b0, lat, color, hit);
    check_eq("current_lat", 64'(lat), 64'd1);
    check_eq("current_color", 64'(color), 64'hFF0A0B0C);
    check_eq("current_hit", 64'(hit), 64'd1);

    // Non-ident and ident 0
    do_req(1'b0, 3, 1'b0, 1'b0, lat, color, hit);
    check_eq("nonid_lat", 64'(lat), 64'd1);
    check_eq("nonid_color", 64'(color), 64'd0);
    check_eq("nonid_hit", 64'(hit), 64'd0);
    do_req(1'b1, 0, 1'b0, 1'b0, lat, color, hit);
    check_eq("id0_hit", 64'(hit), 64'd0);
    check_stats("kw");

    // Duplicates with backpressure; a write attempted while busy is dropped
    write_entry(2, 1'b1, 40, 32'hFF0000FF);
    write_entry(40, 1'b1, 40, 32'hFFFF0000);
    @(negedge clk);
    req_is_ident = 1'b1;
    req_ident    = 10'd40;
    req_valid    = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp(lat);
    check_eq("dup_lat", 64'(lat), 64'd2);
    tbl_wr_en    = 1'b1;
    tbl_wr_idx   = IdxW'(6);
    tbl_wr_valid = 1'b1;
    tbl_wr_ident = 10'd55;
    tbl_wr_color = 32'hFF123456;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("bp_valid", 64'(rsp_valid), 64'd1);
      check_eq("bp_color", 64'(rsp_color), 64'hFF0000FF);
      check_eq("bp_hit", 64'(rsp_hit), 64'd1);
      check_eq("bp_req_ready", 64'(req_ready), 64'd0);
      check_eq("bp_wr_ready", 64'(tbl_wr_ready), 64'd0);
    end
    tbl_wr_en = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    exp_hit++;
    do_req(1'b1, 55, 1'b0, 1'b0, lat, color, hit);
    exp_miss++;
    check_eq("dropwr_lat", 64'(lat), 64'd17);
    check_eq("dropwr_hit", 64'(hit), 64'd0);

    // Write and request on the same edge
    tbl_wr_en    = 1'b1;
    tbl_wr_idx   = '0;
    tbl_wr_valid = 1'b1;
    tbl_wr_ident = 10'd7;
    tbl_wr_color = 32'hFFABCDEF;
    do_req(1'b1, 7, 1'b0, 1'b0, lat, color, hit);
    exp_hit++;
    check_eq("same_lat", 64'(lat), 64'd2);
    check_eq("same_color", 64'(color), 64'hFFABCDEF);
    check_eq("same_hit", 64'(hit), 64'd1);
    check_stats("mid");

    // Statistics clear
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    exp_hit  = 0;
    exp_miss = 0;
    check_stats("clr");

    // Reset in the middle of a miss scan
    write_entry(9, 1'b1, 3, 32'hFF00FFFF);
    @(negedge clk);
    req_is_ident = 1'b1;
    req_ident    = 10'd999;
    req_valid    = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("mrst_req_ready", 64'(req_ready), 64'd1);
    check_eq("mrst_rsp_hit", 64'(rsp_hit), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b1, 3, 1'b0, 1'b0, lat, color, hit);
    exp_miss++;
    check_eq("mrst_lat", 64'(lat), 64'd17);
    check_eq("mrst_color", 64'(color), 64'd0);
    check_eq("mrst_hit", 64'(hit), 64'd0);
    check_stats("mrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
